uart_rx_os_fifo: RTL and testbench
==================================

// Module: uart_rx_os_fifo
// PURPOSE
// Robust UART receive front-end: 16x oversampled 8N1 receiver with input synchronizer,
// start-bit glitch rejection, 3-sample majority vote, framing/overrun detection, and a
// show-ahead RX FIFO. Sits on the far end of the serial link driven by uarttx; feeds
// host logic that pops bytes at its own rate.
// PARAMETERS
// clk_freq    1000000  system clock frequency, Hz
// baud_rate   9600     line rate, bit/s
// FIFO_DEPTH  8        RX FIFO entries; power of 2, >=2
// (derived) TICK_DIV = clk_freq/(baud_rate*16), floor; default 6 -> 96 clk per bit
// PORTS
// clk         in   1   system clock, all logic on posedge
// rst         in   1   asynchronous, active-high reset
// rx          in   1   serial line, idle high, async to clk
// rd_en       in   1   pop FIFO head; ignored when rx_valid=0
// clr_err     in   1   clear sticky error flags
// rx_data     out  8   FIFO head byte, valid while rx_valid=1
// rx_valid    out  1   FIFO not empty
// fifo_count  out  $clog2(FIFO_DEPTH+1)  entries held, 0..FIFO_DEPTH
// busy        out  1   receiver not in IDLE
// frame_err   out  1   sticky: stop bit sampled 0
// overrun     out  1   sticky: good byte arrived with FIFO full and no pop
// parity_err  out  1   sticky: parity mismatch (0 unless UART_PARITY_EN)
// BEHAVIOUR
// - Reset (async): all outputs 0, sync flops 1, state IDLE, FIFO empty, pointers 0.
//   Reset mid-frame aborts; partial byte discarded, never pushed.
// - rx passes 2-FF synchronizer (reset value 1). Tick counter 0..TICK_DIV-1, one-clk
//   tick at wrap; free-running, restarted on start detect. Sample counter 0..15 per bit.
// - IDLE: arm only on falling edge (sync prev=1, now=0) -> START; line held low out of
//   reset does not start a frame.
// - START: at sample 7 read rx; 1 -> glitch, back to IDLE, nothing flagged; 0 -> DATA.
// - DATA: each bit = majority of samples 7,8,9; LSB first into shift reg; after bit 7
//   -> PARITY (if enabled) else STOP.
// - STOP: at majority of samples 7-9: 1 -> push byte, IDLE; 0 -> frame_err=1, byte
//   dropped, -> BRK_WAIT. BRK_WAIT: stay until sync rx=1, then IDLE.
// - Return to IDLE at stop mid-bit permits back-to-back frames.
// - Latency: rx_valid/fifo_count update on the clk edge after the stop-bit decision.
// - FIFO show-ahead: rx_data = mem[rd_ptr] combinationally; pop on rd_en&rx_valid.
//   Pointers log2(FIFO_DEPTH) bits, wrap naturally.
// - Push while full: accepted only if a pop occurs same cycle (count unchanged);
//   else byte dropped, overrun=1, existing contents untouched.
// - Push+pop when empty: push only (pop ignored; rx_valid=0 that cycle).
// - Error flags sticky until clr_err; set event same cycle as clr_err -> flag stays 1.
// CONFIGURATION
// UART_PARITY_EN defined: frame 8E1; PARITY state samples 9th bit (majority), expects
//   even parity over data+bit; mismatch -> parity_err=1, byte dropped, STOP still checked.
// UART_PARITY_EN undefined: 8N1, no PARITY state, parity_err tied 0.
// TESTING (defaults, 96 clk/bit unless stated)
// 1. Send 0xA5 8N1 -> rx_data=0xA5, rx_valid=1, fifo_count=1; rd_en 1 clk -> rx_valid=0, count=0.
// 2. rx low for 20 clk then high -> no push, busy returns 0, no error flags.
// 3. Send 0x3C with stop=0, then rx high -> frame_err=1, count=0; clr_err -> frame_err=0.
// 4. 9 back-to-back bytes 0x00..0x08, no pops -> count=8, overrun=1, pops yield 0x00..0x07.
// 5. FIFO full, rd_en asserted on push cycle of 0x55 -> count stays 8, tail=0x55, overrun=0.
// 6. rst pulse mid-bit-4 of 0xFF, line low after -> FIFO empty, no frame started;
//    UART_PARITY_EN: 0x07 with parity bit 0 -> parity_err=1, count=0.

Source files
------------

// File: rtl/uart_rx_os_fifo.sv
// uart_rx_os_fifo
// 16x oversampled UART receiver (8N1, or 8E1 with UART_PARITY_EN defined) with
// 2-FF input synchronizer, start-bit glitch rejection, 3-sample majority vote,
// sticky framing/overrun/parity flags and a show-ahead receive FIFO.
//
// Build option: `define UART_PARITY_EN for 8E1 framing with parity checking.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-high reset
//   rx         serial line, idle high, asynchronous to clk
//   rd_en      pop FIFO head (ignored while rx_valid=0)
//   clr_err    clear sticky error flags
//   rx_data    FIFO head byte (show-ahead), valid while rx_valid=1
//   rx_valid   FIFO not empty
//   fifo_count entries held, 0..FIFO_DEPTH
//   busy       receiver not idle
//   frame_err  sticky: stop bit sampled 0
//   overrun    sticky: good byte dropped because FIFO full with no pop
//   parity_err sticky: parity mismatch (tied 0 without UART_PARITY_EN)
module uart_rx_os_fifo #(
  parameter int clk_freq   = 1000000,
  parameter int baud_rate  = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx,
  input  logic                            rd_en,
  input  logic                            clr_err,
  output logic [7:0]                      rx_data,
  output logic                            rx_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            busy,
  output logic                            frame_err,
  output logic                            overrun,
  output logic                            parity_err
);

  localparam int TICK_DIV = clk_freq / (baud_rate * 16);
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_BRK    = 3'd4;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic [1:0]    sync;
  logic          rx_s;
  logic          rx_prev;
  logic [1:0]    settle;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    s_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [1:0]    vote;
  logic          maj;
  logic [2:0]    state;
  logic          start_det;
  logic          samp;
  logic          stop_dec;
  logic          push_ok;
  logic          fe_set;
  logic          par_bad;
  logic          push_vld;
  logic [7:0]    push_byte;

  assign rx_s = sync[1];
  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  // The sync chain resets to 1, so a line held low through reset would look
  // like a falling edge once it flushes. settle holds off edge detection until
  // rx_prev reflects a real line sample.
  assign start_det = (state == S_IDLE) && (settle == 2'd3) && rx_prev && !rx_s;

  // Sample s_cnt is taken on the tick where s_cnt holds that value; the vote
  // completes at sample 9 using the stored samples 7 and 8.
  assign samp     = tick && (state != S_IDLE) && (state != S_BRK);
  assign maj      = (vote[0] & vote[1]) | (vote[0] & rx_s) | (vote[1] & rx_s);
  assign stop_dec = samp && (state == S_STOP) && (s_cnt == 4'd9);
  assign push_ok  = stop_dec && maj && !par_bad;
  assign fe_set   = stop_dec && !maj;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync      <= 2'b11;
      rx_prev   <= 1'b1;
      settle    <= 2'd0;
      tick_cnt  <= '0;
      s_cnt     <= 4'd0;
      bit_idx   <= 3'd0;
      shreg     <= 8'd0;
      vote      <= 2'b00;
      state     <= S_IDLE;
      push_vld  <= 1'b0;
      push_byte <= 8'd0;
    end else begin
      sync     <= {sync[0], rx};
      rx_prev  <= rx_s;
      if (settle != 2'd3) settle <= settle + 2'd1;
      push_vld  <= push_ok;
      push_byte <= shreg;

      if (start_det) begin
        // Realign bit timing to the detected edge.
        state    <= S_START;
        tick_cnt <= '0;
        s_cnt    <= 4'd0;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
        if (samp) begin
          s_cnt <= s_cnt + 4'd1;
          if (s_cnt == 4'd7) vote[0] <= rx_s;
          if (s_cnt == 4'd8) vote[1] <= rx_s;
          case (state)
            S_START: begin
              if (s_cnt == 4'd7 && rx_s) state <= S_IDLE;  // glitch, silently ignored
              else if (s_cnt == 4'd15) begin
                state   <= S_DATA;
                bit_idx <= 3'd0;
              end
            end
            S_DATA: begin
              if (s_cnt == 4'd9) shreg <= {maj, shreg[7:1]};
              if (s_cnt == 4'd15) begin
                if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                  state <= S_PARITY;
`else
                  state <= S_STOP;
`endif
                end else begin
                  bit_idx <= bit_idx + 3'd1;
                end
              end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
              if (s_cnt == 4'd15) state <= S_STOP;
            end
`endif
            S_STOP: begin
              // Leave mid stop bit so a back-to-back start edge is not missed.
              if (s_cnt == 4'd9) state <= maj ? S_IDLE : S_BRK;
            end
            default: ;
          endcase
        end
        if (state == S_BRK && rx_s) state <= S_IDLE;
      end
    end
  end

`ifdef UART_PARITY_EN
  logic pe_set;
  assign pe_set = samp && (state == S_PARITY) && (s_cnt == 4'd9) && (^{shreg, maj});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (start_det)   par_bad <= 1'b0;
      else if (pe_set) par_bad <= 1'b1;
      parity_err <= pe_set | (parity_err & ~clr_err);
    end
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Show-ahead FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          pop;
  logic          full;
  logic          push_acc;
  logic          ov_set;

  assign pop      = rd_en && (count != '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  // A push into a full FIFO survives only if a pop frees the slot this cycle.
  assign push_acc = push_vld && (!full || pop);
  assign ov_set   = push_vld && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push_acc) begin
        mem[wr_ptr] <= push_byte;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_acc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      overrun   <= ov_set | (overrun & ~clr_err);
      frame_err <= fe_set | (frame_err & ~clr_err);
    end
  end

  assign rx_data    = mem[rd_ptr];
  assign rx_valid   = (count != '0);
  assign fifo_count = count;

endmodule

// File: tb/tb_uart_rx_os_fifo.sv
// Testbench for uart_rx_os_fifo: directed scenarios plus random bytes, checked
// against a queue-based model of the receive FIFO and sticky flags.
module tb_uart_rx_os_fifo;
  localparam int BIT_CLKS = 96;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] fifo_count;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] q[$];
  logic       ov_exp;
`ifdef UART_PARITY_EN
  logic       par_flip = 1'b0;
`endif

  uart_rx_os_fifo dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .clr_err(clr_err),
    .rx_data(rx_data), .rx_valid(rx_valid), .fifo_count(fifo_count),
    .busy(busy), .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    rx = 1'b0; clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin rx = d[i]; clks(BIT_CLKS); end
`ifdef UART_PARITY_EN
    rx = (^d) ^ par_flip; clks(BIT_CLKS);
`endif
    rx = stop_v; clks(BIT_CLKS);
    rx = 1'b1;
  endtask

  // Model of a good byte arriving with no concurrent pop.
  task automatic model_rx(input logic [7:0] d);
    if (q.size() == 8) ov_exp = 1'b1;
    else q.push_back(d);
  endtask

  task automatic pop_chk(input string tag);
    chk(tag, 32'(rx_data), 32'(q[0]));
    void'(q.pop_front());
    rd_en = 1'b1; clks(1); rd_en = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1; clks(1); clr_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0; ov_exp = 1'b0;
    clks(3);
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_flags", 32'({frame_err, overrun, parity_err}), 0);
    rst = 1'b0; clks(5);

    // Single byte, then pop.
    send_frame(8'hA5, 1'b1); clks(5);
    chk("t1_data", 32'(rx_data), 32'hA5);
    chk("t1_valid", 32'(rx_valid), 1);
    chk("t1_count", 32'(fifo_count), 1);
    chk("t1_busy", 32'(busy), 0);
    rd_en = 1'b1; clks(1); rd_en = 1'b0;
    chk("t1_pop_valid", 32'(rx_valid), 0);
    chk("t1_pop_count", 32'(fifo_count), 0);

    // Short low glitch: start detected then rejected.
    rx = 1'b0; clks(20);
    chk("t2_busy_mid", 32'(busy), 1);
    rx = 1'b1; clks(100);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_count", 32'(fifo_count), 0);
    chk("t2_flags", 32'({frame_err, overrun, parity_err}), 0);

    // Framing error: stop bit low.
    send_frame(8'h3C, 1'b0); clks(10);
    chk("t3_ferr", 32'(frame_err), 1);
    chk("t3_count", 32'(fifo_count), 0);
    chk("t3_busy", 32'(busy), 0);
    clr_pulse();
    chk("t3_ferr_clr", 32'(frame_err), 0);

    // Nine back-to-back bytes, no pops: last one overruns.
    for (int i = 0; i < 9; i++) begin
      send_frame(8'(i), 1'b1);
      model_rx(8'(i));
    end
    clks(5);
    chk("t4_count", 32'(fifo_count), 32'(q.size()));
    chk("t4_overrun", 32'(overrun), 32'(ov_exp));
    clr_pulse(); ov_exp = 1'b0;
    chk("t4_ovr_clr", 32'(overrun), 0);

    // Full FIFO, pop coincident with push of 0x55.
    fork
      send_frame(8'h55, 1'b1);
      begin
        int k = 0;
        while (!dut.push_vld && k < 3000) begin clks(1); k++; end
        chk("t5_push_timeout", 32'(k >= 3000), 0);
        chk("t5_head", 32'(rx_data), 32'(q[0]));
        void'(q.pop_front());
        q.push_back(8'h55);
        rd_en = 1'b1; clks(1); rd_en = 1'b0;
      end
    join
    clks(5);
    chk("t5_count", 32'(fifo_count), 32'(q.size()));
    chk("t5_overrun", 32'(overrun), 0);
    while (q.size() > 0) pop_chk("t5_drain");
    chk("t5_empty", 32'(rx_valid), 0);

    // Reset in bit 4 of 0xFF, line low afterwards.
    rx = 1'b0; clks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin rx = 1'b1; clks(BIT_CLKS); end
    clks(BIT_CLKS / 2);
    rst = 1'b1; rx = 1'b0; clks(3); rst = 1'b0;
    clks(300);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_count", 32'(fifo_count), 0);
    chk("t6_ferr", 32'(frame_err), 0);
    rx = 1'b1; clks(200);
    chk("t6_busy_idle", 32'(busy), 0);

`ifdef UART_PARITY_EN
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1); clks(5);
    par_flip = 1'b0;
    chk("t6p_perr", 32'(parity_err), 1);
    chk("t6p_count", 32'(fifo_count), 0);
    clr_pulse();
    chk("t6p_perr_clr", 32'(parity_err), 0);
`endif

    // Random bytes with random pops between frames.
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      int npop;
      d = 8'($urandom);
      send_frame(d, 1'b1);
      model_rx(d);
      clks(2 + $urandom_range(0, 30));
      npop = $urandom_range(0, 2);
      for (int j = 0; j < npop; j++)
        if (q.size() > 0) pop_chk("rnd_pop");
    end
    chk("rnd_count", 32'(fifo_count), 32'(q.size()));
    chk("rnd_overrun", 32'(overrun), 32'(ov_exp));
    while (q.size() > 0) pop_chk("rnd_drain");
    chk("rnd_empty", 32'(rx_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
